// File: rtl/ioblock_pkg.sv
// Shared definitions for the pad IO block output serializer: FSM encoding and
// pad drive-enable levels.
package ioblock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_TAIL  = 2'd2
  } state_t;

  localparam logic TS_DRIVE = 1'b1;
  localparam logic TS_HIZ   = 1'b0;

  localparam int TAIL_CNT_W = 4;

endpackage

// File: rtl/ioblock_shreg.sv
// WIDTH-bit load/shift register; sout always presents the bit that goes out next
// (MSB or LSB end, chosen by MSB_FIRST).
module ioblock_shreg
  import ioblock_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] q;

  // Load wins over shift so a back-to-back word replaces the drained one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= MSB_FIRST ? {q[WIDTH-2:0], 1'b0} : {1'b0, q[WIDTH-1:1]};
    end
  end

  assign sout = MSB_FIRST ? q[WIDTH-1] : q[0];

endmodule

// File: rtl/ioblock_oser.sv
// Parallel-to-serial transmitter driving the pad IO block OUT/TS pins, with an
// optional TS hold (tail) after each frame before releasing the pad.
module ioblock_oser
  import ioblock_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int TAIL       = 1,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic             IOCLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] DATA,
  input  logic             VALID,
  output logic             READY,
  output logic             OUT,
  output logic             TS,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
  localparam int TAIL_LAST_I = (TAIL > 0) ? TAIL - 1 : 0;
  localparam logic [TAIL_CNT_W-1:0] TAIL_LAST = TAIL_CNT_W'(TAIL_LAST_I);

  state_t                  state, state_d;
  logic [CNT_W-1:0]        bit_cnt, bit_cnt_d;
  logic [TAIL_CNT_W-1:0]   tail_cnt, tail_cnt_d;
  logic                    ready_c, take, load, shift, sout;
  logic                    out_d, ts_d, done_d;

  // Handshake: a word transfers at a posedge where VALID and READY are both 1;
  // DATA is sampled only then. READY depends on state only, never on VALID.
  assign take  = VALID & ready_c;
  assign READY = RST_N & ready_c;
  assign BUSY  = (state != ST_IDLE);

  ioblock_shreg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shreg (
    .clk  (IOCLK),
    .rst_n(RST_N),
    .load (load),
    .shift(shift),
    .din  (DATA),
    .sout (sout)
  );

  // The state describes the bit to be registered onto OUT at the next edge,
  // so OUT, TS and DONE always change together.
  always_comb begin
    state_d    = state;
    bit_cnt_d  = bit_cnt;
    tail_cnt_d = tail_cnt;
    ready_c    = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    out_d      = IDLE_LEVEL;
    ts_d       = TS_HIZ;
    done_d     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        ready_c = 1'b1;
        if (take) begin
          state_d   = ST_SHIFT;
          load      = 1'b1;
          bit_cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        out_d = sout;
        ts_d  = TS_DRIVE;
        shift = 1'b1;
        if (bit_cnt == BIT_LAST) begin
          ready_c = 1'b1;
          done_d  = 1'b1;
          if (take) begin
            load      = 1'b1;
            bit_cnt_d = '0;
          end else if (TAIL > 0) begin
            state_d    = ST_TAIL;
            bit_cnt_d  = '0;
            tail_cnt_d = '0;
          end else begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
          end
        end else begin
          bit_cnt_d = bit_cnt + 1'b1;
        end
      end
      ST_TAIL: begin
        ready_c = 1'b1;
        ts_d    = TS_DRIVE;
        if (take) begin
          state_d    = ST_SHIFT;
          load       = 1'b1;
          bit_cnt_d  = '0;
          tail_cnt_d = '0;
        end else if (tail_cnt == TAIL_LAST) begin
          state_d    = ST_IDLE;
          tail_cnt_d = '0;
        end else begin
          tail_cnt_d = tail_cnt + 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        bit_cnt_d  = '0;
        tail_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge IOCLK) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      tail_cnt <= '0;
      OUT      <= IDLE_LEVEL;
      TS       <= TS_HIZ;
      DONE     <= 1'b0;
    end else begin
      state    <= state_d;
      bit_cnt  <= bit_cnt_d;
      tail_cnt <= tail_cnt_d;
      OUT      <= out_d;
      TS       <= ts_d;
      DONE     <= done_d;
    end
  end

endmodule

// File: tb/tb_ioblock_oser.sv
// Bench for ioblock_oser: two instances (MSB-first/TAIL=1 and LSB-first/TAIL=0)
// checked each cycle against a per-cycle output timeline model.
module tb_ioblock_oser;

  localparam int W  = 8;
  localparam int TL = 32;

  typedef struct packed {
    logic out;
    logic ts;
    logic done;
    logic data;
  } ent_t;

  localparam ent_t IDLE_E = '{out: 1'b1, ts: 1'b0, done: 1'b0, data: 1'b0};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid;
  logic [W-1:0] data;
  logic         ready_a, out_a, ts_a, busy_a, done_a;
  logic         ready_b, out_b, ts_b, busy_b, done_b;
  logic [1:0]   d_out, d_ts, d_done, d_busy, d_ready;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ioblock_oser #(.WIDTH(W), .MSB_FIRST(1'b1), .TAIL(1), .IDLE_LEVEL(1'b1)) dut_a (
    .IOCLK(clk), .RST_N(rst_n), .DATA(data), .VALID(valid), .READY(ready_a),
    .OUT(out_a), .TS(ts_a), .BUSY(busy_a), .DONE(done_a)
  );

  ioblock_oser #(.WIDTH(W), .MSB_FIRST(1'b0), .TAIL(0), .IDLE_LEVEL(1'b1)) dut_b (
    .IOCLK(clk), .RST_N(rst_n), .DATA(data), .VALID(valid), .READY(ready_b),
    .OUT(out_b), .TS(ts_b), .BUSY(busy_b), .DONE(done_b)
  );

  assign d_out   = {out_b, out_a};
  assign d_ts    = {ts_b, ts_a};
  assign d_done  = {done_b, done_a};
  assign d_busy  = {busy_b, busy_a};
  assign d_ready = {ready_b, ready_a};

  // ---------------- reference model ----------------
  // tl[g][k] = expected pad output after the (k+1)-th upcoming edge.
  ent_t tl [2][TL];
  ent_t cur [2];
  logic [1:0] exp_busy;
  logic armed = 1'b0;

  function automatic int tail_of(int g);
    return (g == 0) ? 1 : 0;
  endfunction

  function automatic ent_t frame_ent(int g, logic [W-1:0] d, int k);
    ent_t e;
    e = IDLE_E;
    if (k < W) begin
      e.out  = d[(g == 0) ? (W - 1 - k) : k];
      e.ts   = 1'b1;
      e.data = 1'b1;
      e.done = (k == W - 1);
    end else if (k < W + tail_of(g)) begin
      e.out = 1'b1;
      e.ts  = 1'b1;
    end
    return e;
  endfunction

  always @(posedge clk) begin
    armed <= 1'b1;
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        for (int k = 0; k < TL; k++) tl[g][k] <= IDLE_E;
        cur[g]      <= IDLE_E;
        exp_busy[g] <= 1'b0;
      end else begin
        cur[g] <= tl[g][0];
        if (valid && !tl[g][1].data) begin
          for (int k = 0; k < TL; k++) tl[g][k] <= frame_ent(g, data, k);
          exp_busy[g] <= 1'b1;
        end else begin
          for (int k = 0; k < TL - 1; k++) tl[g][k] <= tl[g][k+1];
          tl[g][TL-1] <= IDLE_E;
          exp_busy[g] <= tl[g][1].ts;
        end
      end
    end
  end

  task automatic check(string name, int g, logic got, logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s[inst%0d] @%0t got=%b exp=%b", name, g, $time, got, exp);
    end
  endtask

  task automatic pin(string name, int g, logic [15:0] got, logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s[inst%0d] got=%b exp=%b", name, g, got, exp);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (armed) begin
      for (int g = 0; g < 2; g++) begin
        check("out",   g, d_out[g],   cur[g].out);
        check("ts",    g, d_ts[g],    cur[g].ts);
        check("done",  g, d_done[g],  cur[g].done);
        check("busy",  g, d_busy[g],  exp_busy[g]);
        check("ready", g, d_ready[g], rst_n & ~tl[g][1].data);
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [15:0] co [2];
  logic [15:0] ct [2];
  logic [15:0] cd [2];

  // Called at posedge+2 with VALID/DATA set; returns at posedge+2 of the handshake edge.
  task automatic handshake();
    int   n = 0;
    logic r;
    do begin
      @(negedge clk);
      r = ready_a;
      @(posedge clk);
      #2;
      n++;
    end while (!r && n < 100);
    check("handshake", 0, r, 1'b1);
  endtask

  task automatic capture(int n, int drop_k);
    for (int g = 0; g < 2; g++) begin
      co[g] = '0; ct[g] = '0; cd[g] = '0;
    end
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (k == drop_k) begin
        #2;
        valid = 1'b0;
      end
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        co[g] = {co[g][14:0], d_out[g]};
        ct[g] = {ct[g][14:0], d_ts[g]};
        cd[g] = {cd[g][14:0], d_done[g]};
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy_a || busy_b) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", 0, busy_a | busy_b, 1'b0);
    @(posedge clk);
    #2;
  endtask

  task automatic send_one(logic [W-1:0] d);
    data  = d;
    valid = 1'b1;
    handshake();
    valid = 1'b0;
  endtask

  task automatic back_to_back(logic [W-1:0] w0, logic [W-1:0] w1);
    data  = w0;
    valid = 1'b1;
    handshake();
    data = w1;
    capture(16, 7);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    valid = 1'b1;
    data  = 8'h5A;

    // Reset held with VALID high: everything parked.
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_ready", 0, ready_a, 1'b0);
      check("rst_ts",    0, ts_a,    1'b0);
      check("rst_out",   0, out_a,   1'b1);
      check("rst_busy",  0, busy_a,  1'b0);
      check("rst_done",  0, done_a,  1'b0);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    valid = 1'b0;
    @(negedge clk);
    check("rel_ready", 0, ready_a, 1'b1);
    check("rel_ready", 1, ready_b, 1'b1);
    @(posedge clk);
    #2;

    // Single word 0xA5.
    send_one(8'hA5);
    capture(10, -1);
    pin("a5_out",  0, co[0], 16'b1010010111);
    pin("a5_ts",   0, ct[0], 16'b1111111110);
    pin("a5_done", 0, cd[0], 16'b0000000100);
    pin("a5_out",  1, co[1], 16'b1010010111);
    pin("a5_ts",   1, ct[1], 16'b1111111100);
    pin("a5_done", 1, cd[1], 16'b0000000100);
    wait_idle();

    // Back-to-back 0xFF then 0x00.
    back_to_back(8'hFF, 8'h00);
    for (int g = 0; g < 2; g++) begin
      pin("b2b_out",  g, co[g], 16'hFF00);
      pin("b2b_ts",   g, ct[g], 16'hFFFF);
      pin("b2b_done", g, cd[g], 16'b0000000100000001);
    end
    wait_idle();

    // 0x3C presented while the current word is mid-frame.
    back_to_back(8'hA5, 8'h3C);
    for (int g = 0; g < 2; g++) begin
      pin("stall_out",  g, co[g], 16'b1010010100111100);
      pin("stall_done", g, cd[g], 16'b0000000100000001);
    end
    wait_idle();

    // 0x01: bit order and tail length differ between instances.
    send_one(8'h01);
    capture(10, -1);
    pin("x01_out", 0, co[0], 16'b0000000111);
    pin("x01_ts",  0, ct[0], 16'b1111111110);
    pin("x01_out", 1, co[1], 16'b1000000011);
    pin("x01_ts",  1, ct[1], 16'b1111111100);
    wait_idle();

    // Reset in the middle of a frame.
    send_one(8'hA5);
    capture(3, -1);
    pin("mid_out", 0, co[0], 16'b101);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check("midrst_ts",   g, d_ts[g],   1'b0);
      check("midrst_out",  g, d_out[g],  1'b1);
      check("midrst_done", g, d_done[g], 1'b0);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    send_one(8'h81);
    capture(8, -1);
    pin("x81_out", 0, co[0], 16'b10000001);
    pin("x81_out", 1, co[1], 16'b10000001);
    wait_idle();

    // Randomized traffic with occasional reset pulses.
    repeat (700) begin
      @(posedge clk);
      #2;
      valid = ($urandom_range(0, 99) < 65);
      data  = W'($urandom);
      rst_n = ($urandom_range(0, 149) != 0);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
